// File: rtl/mda_video_timing.sv
// rtl/mda_video_timing.sv - MDA-style programmable video timing generator with cursor/char blink
module mda_video_timing #(
    parameter int                 HW        = 11,
    parameter int                 VW        = 10,
    parameter int                 BLINK_W   = 24,
    parameter logic [BLINK_W-1:0] BLINK_MAX = 24'd9100000
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic [HW-1:0] h_total,
    input  logic [HW-1:0] h_active,
    input  logic [HW-1:0] h_sync_start,
    input  logic [HW-1:0] h_sync_end,
    input  logic [VW-1:0] v_total,
    input  logic [VW-1:0] v_active,
    input  logic [VW-1:0] v_sync_start,
    input  logic [VW-1:0] v_sync_end,
    input  logic          hsync_pol,
    input  logic          vsync_pol,
    output logic          hsync,
    output logic          vsync,
    output logic          display_enable,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          line_start,
    output logic          frame_start,
    output logic          cursor_blink,
    output logic          char_blink
);

    logic [HW-1:0]      h_total_s, h_active_s, h_sync_start_s, h_sync_end_s;
    logic [VW-1:0]      v_total_s, v_active_s, v_sync_start_s, v_sync_end_s;
    logic               hsync_pol_s, vsync_pol_s;
    logic [BLINK_W-1:0] blink_cnt;

    logic line_last;
    logic frame_last;
    logic h_in_active;
    logic v_in_active;
    logic h_in_sync;
    logic v_in_sync;
    logic blink_wrap;

    // Counter wrap points; subtraction is modulo 2^W so a zero total gives a full-range count.
    assign line_last  = (hcount == h_total_s - HW'(1));
    assign frame_last = line_last && (vcount == v_total_s - VW'(1));

    // An active width larger than the total means the whole line (or frame) is visible.
    assign h_in_active = (h_active_s > h_total_s) || (hcount < h_active_s);
    assign v_in_active = (v_active_s > v_total_s) || (vcount < v_active_s);

    // An empty or inverted sync window never matches, so sync stays inactive.
    assign h_in_sync = (hcount >= h_sync_start_s) && (hcount < h_sync_end_s);
    assign v_in_sync = (vcount >= v_sync_start_s) && (vcount < v_sync_end_s);

    assign blink_wrap = (blink_cnt == BLINK_MAX - BLINK_W'(1));

    // Shadow copies of the timing inputs, reloaded only at frame boundaries and in reset.
    always_ff @(posedge clk) begin
        if (!reset_l || frame_last) begin
            h_total_s      <= h_total;
            h_active_s     <= h_active;
            h_sync_start_s <= h_sync_start;
            h_sync_end_s   <= h_sync_end;
            v_total_s      <= v_total;
            v_active_s     <= v_active;
            v_sync_start_s <= v_sync_start;
            v_sync_end_s   <= v_sync_end;
            hsync_pol_s    <= hsync_pol;
            vsync_pol_s    <= vsync_pol;
        end
    end

    // Pixel and line counters.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            hcount <= '0;
            vcount <= '0;
        end else if (line_last) begin
            hcount <= '0;
            vcount <= frame_last ? '0 : vcount + VW'(1);
        end else begin
            hcount <= hcount + HW'(1);
        end
    end

    // Registered decode of the current position, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            hsync          <= ~hsync_pol;
            vsync          <= ~vsync_pol;
            display_enable <= 1'b0;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            hsync          <= h_in_sync ? hsync_pol_s : ~hsync_pol_s;
            vsync          <= v_in_sync ? vsync_pol_s : ~vsync_pol_s;
            display_enable <= h_in_active && v_in_active;
            line_start     <= (hcount == '0);
            frame_start    <= (hcount == '0) && (vcount == '0);
        end
    end

    // Free-running blink prescaler; char_blink toggles on every other wrap.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            blink_cnt    <= '0;
            cursor_blink <= 1'b0;
            char_blink   <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt    <= '0;
            cursor_blink <= ~cursor_blink;
            if (cursor_blink) begin
                char_blink <= ~char_blink;
            end
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

endmodule

// File: tb/tb_mda_video_timing.sv
// tb/tb_mda_video_timing.sv - directed self-checking bench for mda_video_timing
module tb_mda_video_timing;

    logic        clk = 1'b0;
    logic        reset_l;
    logic [10:0] h_total, h_active, h_sync_start, h_sync_end;
    logic [9:0]  v_total, v_active, v_sync_start, v_sync_end;
    logic        hsync_pol, vsync_pol;
    logic        hsync, vsync, display_enable, line_start, frame_start;
    logic        cursor_blink, char_blink;
    logic [10:0] hcount;
    logic [9:0]  vcount;

    int checks = 0;
    int fails  = 0;
    int eh, ev, cnt;

    mda_video_timing #(
        .HW(11), .VW(10), .BLINK_W(24), .BLINK_MAX(24'd4)
    ) dut (
        .clk(clk), .reset_l(reset_l),
        .h_total(h_total), .h_active(h_active),
        .h_sync_start(h_sync_start), .h_sync_end(h_sync_end),
        .v_total(v_total), .v_active(v_active),
        .v_sync_start(v_sync_start), .v_sync_end(v_sync_end),
        .hsync_pol(hsync_pol), .vsync_pol(vsync_pol),
        .hsync(hsync), .vsync(vsync), .display_enable(display_enable),
        .hcount(hcount), .vcount(vcount),
        .line_start(line_start), .frame_start(frame_start),
        .cursor_blink(cursor_blink), .char_blink(char_blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic base_cfg();
        h_total = 11'd10; h_active = 11'd6; h_sync_start = 11'd7; h_sync_end = 11'd9;
        v_total = 10'd5;  v_active = 10'd3; v_sync_start = 10'd4; v_sync_end = 10'd5;
        hsync_pol = 1'b1; vsync_pol = 1'b1;
    endtask

    initial begin
        // Reset state with the basic 10x5 configuration
        base_cfg();
        reset_l = 1'b0;
        step(); step(); step();
        check("rst_hcount", 32'(hcount), 0);
        check("rst_vcount", 32'(vcount), 0);
        check("rst_de", 32'(display_enable), 0);
        check("rst_ls", 32'(line_start), 0);
        check("rst_fs", 32'(frame_start), 0);
        check("rst_hsync", 32'(hsync), 0);
        check("rst_vsync", 32'(vsync), 0);
        check("rst_cursor", 32'(cursor_blink), 0);
        check("rst_char", 32'(char_blink), 0);

        // Two full frames: after edge k the outputs decode position k-1
        reset_l = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            eh = (k - 1) % 10;
            ev = ((k - 1) / 10) % 5;
            check("f_de", 32'(display_enable), 32'((eh < 6) && (ev < 3)));
            check("f_hsync", 32'(hsync), 32'((eh == 7) || (eh == 8)));
            check("f_vsync", 32'(vsync), 32'(ev == 4));
            check("f_ls", 32'(line_start), 32'(eh == 0));
            check("f_fs", 32'(frame_start), 32'((eh == 0) && (ev == 0)));
            check("f_hcount", 32'(hcount), 32'(k % 10));
            check("f_vcount", 32'(vcount), 32'((k / 10) % 5));
            check("f_cursor", 32'(cursor_blink), 32'((k / 4) % 2));
            check("f_char", 32'(char_blink), 32'((k / 8) % 2));
        end

        // Negative hsync polarity; h_total changed mid-frame
        hsync_pol = 1'b0;
        reset_l = 1'b0;
        step();
        check("neg_rst_hsync", 32'(hsync), 1);
        reset_l = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            eh = (k - 1) % 10;
            check("neg_hsync", 32'(hsync), 32'(!((eh == 7) || (eh == 8))));
            check("neg_hcount", 32'(hcount), 32'(k % 10));
            if (k == 25) h_total = 11'd12;
        end
        step();
        check("reload_fs", 32'(frame_start), 1);
        check("reload_hcount", 32'(hcount), 1);
        cnt = 0;
        do begin
            step();
            cnt++;
            if (hcount == 11'd11) check("wide_line_vcount", 32'(vcount < 10'd5), 1);
        end while (!frame_start && cnt < 80);
        check("frame_len_12", 32'(cnt), 60);

        // Empty sync window and active width beyond total
        base_cfg();
        h_sync_start = 11'd8; h_sync_end = 11'd8; h_active = 11'd15;
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            ev = ((k - 1) / 10) % 5;
            check("nosync_hsync", 32'(hsync), 0);
            check("wide_de", 32'(display_enable), 32'(ev < 3));
        end

        // Reset asserted mid-frame at hcount=5, vcount=2
        base_cfg();
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
        for (int k = 1; k <= 25; k++) step();
        check("mid_hcount", 32'(hcount), 5);
        check("mid_vcount", 32'(vcount), 2);
        reset_l = 1'b0;
        step();
        check("mid_rst_hcount", 32'(hcount), 0);
        check("mid_rst_vcount", 32'(vcount), 0);
        check("mid_rst_de", 32'(display_enable), 0);
        check("mid_rst_fs", 32'(frame_start), 0);
        reset_l = 1'b1;
        step();
        check("post_fs", 32'(frame_start), 1);
        check("post_ls", 32'(line_start), 1);
        check("post_de", 32'(display_enable), 1);
        check("post_hcount", 32'(hcount), 1);
        step();
        check("post_fs_drop", 32'(frame_start), 0);
        check("post_ls_drop", 32'(line_start), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mda_video_timing.md
MDA_VIDEO_TIMING -- requirements
Module: mda_video_timing

Interface
REQ-001 Parameter HW, default 11: width of the horizontal timing inputs and hcount.
REQ-002 Parameter VW, default 10: width of the vertical timing inputs and vcount.
REQ-003 Parameter BLINK_W, default 24: width of the blink prescaler.
REQ-004 Parameter BLINK_MAX, default 24'd9100000: clocks per cursor-blink half-period.
REQ-005 Port list (name, direction, width, meaning), one entry per line:
- clk  in  1  pixel clock; the only clock.
- reset_l  in  1  reset; synchronous, active-low.
- h_total  in  HW  pixels per line.
- h_active  in  HW  visible pixels per line.
- h_sync_start  in  HW  first hsync pixel.
- h_sync_end  in  HW  first pixel after hsync.
- v_total  in  VW  lines per frame.
- v_active  in  VW  visible lines.
- v_sync_start  in  VW  first vsync line.
- v_sync_end  in  VW  first line after vsync.
- hsync_pol  in  1  1 = hsync active-high.
- vsync_pol  in  1  1 = vsync active-high.
- hsync  out  1  registered horizontal sync.
- vsync  out  1  registered vertical sync.
- display_enable  out  1  registered active-video flag.
- hcount  out  HW  current pixel index.
- vcount  out  VW  current line index.
- line_start  out  1  one-cycle pulse when hcount = 0.
- frame_start  out  1  one-cycle pulse when hcount = 0 and vcount = 0.
- cursor_blink  out  1  cursor blink phase.
- char_blink  out  1  character blink phase, half the rate of cursor_blink.

Function
REQ-006 All timing inputs and both polarity bits SHALL be captured into shadow registers only on the last pixel of a frame (hcount = h_total_s-1 and vcount = v_total_s-1) and during reset; all logic uses only the shadow copies (suffix _s).
REQ-007 hcount SHALL increment each clk and wrap to 0 after h_total_s-1; arithmetic is modulo 2^HW, so h_total_s = 0 gives a 2^HW-pixel line.
REQ-008 vcount SHALL increment when hcount wraps and wrap to 0 after v_total_s-1; arithmetic is modulo 2^VW, so v_total_s = 0 gives 2^VW lines.
REQ-009 hsync, vsync, display_enable, line_start and frame_start SHALL be registered and valid one clk after the hcount/vcount value they decode (one cycle latency).
REQ-010 display_enable SHALL be 1 iff hcount < h_active_s and vcount < v_active_s.
REQ-011 hsync SHALL equal hsync_pol_s iff h_sync_start_s <= hcount < h_sync_end_s, and ~hsync_pol_s otherwise.
REQ-012 vsync SHALL follow the same rule as hsync using vcount, the vertical shadow values and vsync_pol_s.
REQ-013 If h_sync_end_s <= h_sync_start_s, hsync SHALL stay inactive for the whole line; the same rule applies to vsync.
REQ-014 If h_active_s > h_total_s, display_enable SHALL be high for the whole line; the same rule applies vertically.
REQ-015 The blink prescaler SHALL count 0 to BLINK_MAX-1 and then wrap.
REQ-016 cursor_blink SHALL toggle on each prescaler wrap.
REQ-017 char_blink SHALL toggle on every second prescaler wrap.
REQ-018 The blink logic SHALL run independently of the video timing and of any shadow reload.
REQ-019 When a shadow reload occurs with changed inputs, the first frame using the new values SHALL start at the next clk (hcount = 0, vcount = 0), with no glitch or partial line.

Reset
REQ-020 While reset_l = 0 at a clk edge, the following SHALL be cleared to 0: hcount, vcount, the blink prescaler, cursor_blink, char_blink, display_enable, line_start and frame_start.
REQ-021 While reset_l = 0 at a clk edge, the shadows SHALL load from the inputs, hsync SHALL be set to ~hsync_pol and vsync to ~vsync_pol.
REQ-022 The first clk with reset_l = 1 SHALL decode hcount = 0, vcount = 0; frame_start and line_start SHALL be 1 on the following clk.
REQ-023 Reset asserted mid-frame SHALL take effect at the next clk edge with no completion of the current line.

Verification
REQ-024 Config h_total=10, h_active=6, h_sync 7..9, v_total=5, v_active=3, v_sync 4..5, pol=1,1 -> per line: display_enable high 6 clks, hsync high 2 clks (hcount 7,8), period 10; vsync high exactly line 4; frame 50 clks.
REQ-025 Same config with hsync_pol=0 -> hsync low only at hcount 7,8 and high otherwise; after reset, hsync=1 before the first decode.
REQ-026 Change h_total to 12 mid-frame -> the current frame keeps the 10-clk period; the frame after the next frame_start is 60 clks.
REQ-027 BLINK_MAX=4 -> cursor_blink toggles every 4 clks and char_blink every 8; both are 0 after reset.
REQ-028 h_sync_start=8, h_sync_end=8 and h_active=15 > h_total=10 -> hsync never active; display_enable high all line.
REQ-029 Assert reset_l=0 at hcount=5, vcount=2 for one clk -> next cycle hcount=0, vcount=0, display_enable=0; frame_start pulses one clk later.
